// File: rtl/mac_frame_arbiter.sv
// Round-robin frame arbiter in front of a shared sum-of-squares accumulator.
// Each grant covers FRAME_LEN samples; the frame sum is returned tagged with the requester id.
module mac_frame_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  output logic              req1_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [ACC_W-1:0]  res_f,
  output logic              res_ovf
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned SQ_W  = 2 * DATA_W;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

  state_t             state, state_n;
  logic               grant, grant_n;
  logic               rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic               ovf, ovf_n;
  logic               s1_valid, s1_valid_n;
  logic [DATA_W-1:0]  s1_data, s1_data_n;
  logic               ready0_n, ready1_n;
  logic               res_valid_n, res_id_n, res_ovf_n;
  logic [ACC_W-1:0]   res_f_n;

  logic               accept_c;
  logic [DATA_W-1:0]  sample_c;
  logic [SQ_W-1:0]    square_c;
  logic [SUM_W-1:0]   sum_c;

  // Datapath: square of the stage-1 sample; the extra sum bit is the carry-out.
  always_comb begin
    accept_c = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    sample_c = grant ? req1_a : req0_a;
    square_c = SQ_W'(s1_data) * SQ_W'(s1_data);
    sum_c    = {1'b0, acc} + SUM_W'(square_c);
  end

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    rr_ptr_n    = rr_ptr;
    count_n     = count;
    acc_n       = acc;
    ovf_n       = ovf;
    s1_valid_n  = accept_c;
    s1_data_n   = s1_data;
    res_valid_n = res_valid;
    res_id_n    = res_id;
    res_f_n     = res_f;
    res_ovf_n   = res_ovf;

    if (s1_valid) begin
      acc_n = sum_c[ACC_W-1:0];
      ovf_n = ovf | sum_c[ACC_W];
    end
    if (accept_c) begin
      s1_data_n = sample_c;
      count_n   = count + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_n = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
          acc_n   = '0;
          ovf_n   = 1'b0;
          count_n = '0;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c && count_n == CNT_W'(FRAME_LEN)) state_n = DRAIN;
      end
      DRAIN: state_n = RESULT;
      RESULT: begin
        // First RESULT cycle captures the finished sum; later cycles wait for the consumer.
        if (!res_valid) begin
          res_valid_n = 1'b1;
          res_id_n    = grant;
          res_f_n     = acc;
          res_ovf_n   = ovf;
        end else if (res_ready) begin
          res_valid_n = 1'b0;
          rr_ptr_n    = ~res_id;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    ready0_n = (state_n == ACCUM) && !grant_n;
    ready1_n = (state_n == ACCUM) && grant_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      rr_ptr     <= 1'b0;
      count      <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_f      <= '0;
      res_ovf    <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      rr_ptr     <= rr_ptr_n;
      count      <= count_n;
      acc        <= acc_n;
      ovf        <= ovf_n;
      s1_valid   <= s1_valid_n;
      s1_data    <= s1_data_n;
      req0_ready <= ready0_n;
      req1_ready <= ready1_n;
      res_valid  <= res_valid_n;
      res_id     <= res_id_n;
      res_f      <= res_f_n;
      res_ovf    <= res_ovf_n;
    end
  end

endmodule

// File: tb/tb_mac_frame_arbiter.sv
// Scoreboard bench for mac_frame_arbiter: queued requester drivers, result monitor, directed frames.
module tb_mac_frame_arbiter;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 20;

  typedef struct {
    int id;
    int f;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              rv [2];
  logic [DATA_W-1:0] ra [2];
  logic              rr [2];
  logic              res_valid, res_ready, res_id, res_ovf;
  logic [ACC_W-1:0]  res_f;

  logic              v17, rdy17, rdy17b, res17_valid, res17_id, res17_ovf;
  logic [DATA_W-1:0] a17;
  logic [ACC_W-1:0]  res17_f;

  int   q [2][$];
  int   n_acc [2];
  exp_t exp_q[$];
  exp_t exp17_q[$];
  int   total = 0;
  int   bad   = 0;

  mac_frame_arbiter #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAME_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(rv[0]), .req0_a(ra[0]), .req0_ready(rr[0]),
    .req1_valid(rv[1]), .req1_a(ra[1]), .req1_ready(rr[1]),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_f(res_f), .res_ovf(res_ovf)
  );

  mac_frame_arbiter #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAME_LEN(17)) dut17 (
    .clk(clk), .reset(reset),
    .req0_valid(v17), .req0_a(a17), .req0_ready(rdy17),
    .req1_valid(1'b0), .req1_a(8'd0), .req1_ready(rdy17b),
    .res_valid(res17_valid), .res_ready(1'b1), .res_id(res17_id),
    .res_f(res17_f), .res_ovf(res17_ovf)
  );

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Requester drivers: negative queue entries are one-cycle bubbles.
  for (genvar g = 0; g < 2; g++) begin : g_drv
    initial begin
      bit took;
      took     = 1'b0;
      n_acc[g] = 0;
      rv[g]    = 1'b0;
      ra[g]    = '0;
      forever begin
        @(negedge clk);
        if (took && q[g].size() > 0) begin
          void'(q[g].pop_front());
          n_acc[g]++;
        end
        if (q[g].size() > 0 && q[g][0] < 0) begin
          void'(q[g].pop_front());
          rv[g] = 1'b0;
        end else if (q[g].size() > 0) begin
          rv[g] = 1'b1;
          ra[g] = DATA_W'(q[g][0]);
        end else begin
          rv[g] = 1'b0;
        end
        #1 took = rv[g] && rr[g] && !reset;
      end
    end
  end

  // Result monitor for both instances, plus grant exclusivity.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        chk("ready_exclusive", int'(rr[0] && rr[1]), 0);
        chk("dut17_req1_ready", int'(rdy17b), 0);
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("res_id", int'(res_id), e.id);
            chk("res_f", int'(res_f), e.f);
            chk("res_ovf", int'(res_ovf), e.ovf);
          end
        end
        if (res17_valid) begin
          if (exp17_q.size() == 0) chk("unexpected_result17", 1, 0);
          else begin
            e = exp17_q.pop_front();
            chk("res17_id", int'(res17_id), e.id);
            chk("res17_f", int'(res17_f), e.f);
            chk("res17_ovf", int'(res17_ovf), e.ovf);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int id, input int f, input int ovf);
    exp_t e;
    e.id = id; e.f = f; e.ovf = ovf;
    return e;
  endfunction

  // Returns at the first negedge (+2) where queue g is empty; counts cycles the other ready was high.
  task automatic wait_drained(input int g, input string name, output int other_hi);
    int n;
    n = 0;
    other_hi = 0;
    do begin
      @(negedge clk);
      #2;
      if (rr[1-g]) other_hi++;
      n++;
    end while (q[g].size() > 0 && n < 500);
    if (q[g].size() > 0) chk({name, "_drain_timeout"}, 1, 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((exp_q.size() > 0 || res_valid) && n < 500);
    if (exp_q.size() > 0 || res_valid) chk({name, "_idle_timeout"}, 1, 0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_req0_ready"}, int'(rr[0]), 0);
    chk({name, "_req1_ready"}, int'(rr[1]), 0);
    chk({name, "_res_valid"}, int'(res_valid), 0);
    chk({name, "_res_id"}, int'(res_id), 0);
    chk({name, "_res_f"}, int'(res_f), 0);
    chk({name, "_res_ovf"}, int'(res_ovf), 0);
  endtask

  initial begin
    int hi, n, base;
    reset     = 1'b1;
    res_ready = 1'b1;
    v17       = 1'b0;
    a17       = '0;
    repeat (2) @(negedge clk);
    #2;
    check_zero_outputs("reset");
    reset = 1'b0;

    // 1: single requester, result exactly two clocks after the last accept
    @(negedge clk);
    q[0] = '{1, 2, 3, 4};
    exp_q.push_back(mk(0, 30, 0));
    wait_drained(0, "t1", hi);
    chk("t1_valid_at_accept+0", int'(res_valid), 0);
    @(negedge clk); #2;
    chk("t1_valid_at_accept+1", int'(res_valid), 0);
    @(negedge clk); #2;
    chk("t1_valid_at_accept+2", int'(res_valid), 1);
    wait_idle("t1");

    // 2: both requesters valid from reset, round-robin frames
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q[0] = '{10, 10, 10, 10, 10, 10, 10, 10};
    q[1] = '{21, 36, 0, 0};
    exp_q.push_back(mk(0, 400, 0));
    exp_q.push_back(mk(1, 1737, 0));
    exp_q.push_back(mk(0, 400, 0));
    wait_drained(1, "t2a", hi);
    wait_drained(0, "t2b", hi);
    wait_idle("t2");

    // 3: granted requester stalls mid-frame
    @(negedge clk);
    q[1] = '{5, 5, -1, -1, -1, 5, 5};
    exp_q.push_back(mk(1, 100, 0));
    wait_drained(1, "t3", hi);
    chk("t3_req0_ready_cycles", hi, 0);
    wait_idle("t3");

    // 6: reset after two accepts discards the frame
    @(negedge clk);
    base = n_acc[0];
    q[0] = '{9, 9, 9, 9};
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (n_acc[0] < base + 2 && n < 200);
    chk("t6_two_accepts", int'(n_acc[0] >= base + 2), 1);
    reset = 1'b1;
    q[0].delete();
    @(negedge clk); #2;
    check_zero_outputs("t6");
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk); #2;
      chk("t6_no_result", int'(res_valid), 0);
    end
    q[0] = '{1, 1, 1, 1};
    exp_q.push_back(mk(0, 4, 0));
    wait_drained(0, "t6", hi);
    wait_idle("t6");

    // 4: consumer back-pressure holds the result and blocks new grants
    @(negedge clk);
    res_ready = 1'b0;
    q[0] = '{2, 2, 2, 2};
    exp_q.push_back(mk(0, 16, 0));
    wait_drained(0, "t4", hi);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    chk("t4_res_valid_seen", int'(res_valid), 1);
    q[1] = '{3, 3, 3, 3};
    exp_q.push_back(mk(1, 36, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("t4_hold_valid", int'(res_valid), 1);
      chk("t4_hold_id", int'(res_id), 0);
      chk("t4_hold_f", int'(res_f), 16);
      chk("t4_hold_ovf", int'(res_ovf), 0);
      chk("t4_hold_req1_ready", int'(rr[1]), 0);
      chk("t4_hold_req0_ready", int'(rr[0]), 0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk); #2;
    chk("t4_release_valid", int'(res_valid), 0);
    chk("t4_release_idle_ready", int'(rr[1]), 0);
    @(negedge clk); #2;
    chk("t4_next_grant", int'(rr[1]), 1);
    wait_drained(1, "t4b", hi);
    wait_idle("t4b");

    // 5a: full-scale samples, no overflow at FRAME_LEN=4
    @(negedge clk);
    q[0] = '{255, 255, 255, 255};
    exp_q.push_back(mk(0, 260100, 0));
    wait_drained(0, "t5a", hi);
    wait_idle("t5a");

    // 5b: full-scale samples wrap at FRAME_LEN=17
    exp17_q.push_back(mk(0, 56849, 1));
    n = 0;
    hi = 0;
    @(negedge clk);
    v17 = 1'b1;
    a17 = 8'd255;
    do begin
      #2;
      if (v17 && rdy17) n++;
      @(negedge clk);
      if (n >= 17) v17 = 1'b0;
      hi++;
    end while (v17 && hi < 300);
    chk("t5b_accepts", n, 17);
    n = 0;
    while (exp17_q.size() > 0 && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    chk("t5b_result_seen", exp17_q.size(), 0);
    chk("final_exp_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
